// File: rtl/mem_out_sync.sv
// Purpose: synchronous output memory with byte-enable writes, power-on clear and request error strobe.
// Latency: a read returns data one cycle after the request; a write is visible to a read on the next cycle.
// Backpressure: none; ocupado marks the clear sequence, during which requests are dropped without error.
module mem_out_sync #(
    parameter int ANCHO = 32,
    parameter int PROF  = 32,
    parameter int AW    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [AW-1:0]      direccion,
    input  logic               Wen,
    input  logic               Ren,
    input  logic [ANCHO/8-1:0] be,
    input  logic [ANCHO-1:0]   datoEscritura,
    output logic [ANCHO-1:0]   datoLectura,
    output logic               lectura_valida,
    output logic               ocupado,
    output logic               error
);

    localparam int IW = (PROF > 1) ? $clog2(PROF) : 1;
    localparam int NB = ANCHO / 8;
    localparam logic [AW:0] PROF_A = (AW + 1)'(PROF);
    localparam logic [IW-1:0] LAST = IW'(PROF - 1);

    typedef enum logic {LIMPIA, LISTA} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      cnt_q, cnt_d;
    logic [ANCHO-1:0]   mem_q [PROF];
    logic [ANCHO-1:0]   mem_d [PROF];
    logic [ANCHO-1:0]   rd_dat_q, rd_dat_d;
    logic               vld_q, vld_d;
    logic               err_q, err_d;
    logic               in_range;
    logic               rejected;
    logic [IW-1:0]      idx;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        rd_dat_d = rd_dat_q;
        vld_d    = 1'b0;
        err_d    = 1'b0;
        // Full-width compare first so high address bits can never alias into the array.
        in_range = {1'b0, direccion} < PROF_A;
        rejected = (Wen || Ren) && (!in_range || (Wen && Ren));
        idx      = direccion[IW-1:0];

        case (state_q)
            LIMPIA: begin
                mem_d[cnt_q] = '0;
                if (cnt_q == LAST) begin
                    state_d = LISTA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
            LISTA: begin
                if (rejected) begin
                    err_d = 1'b1;
                end else if (Wen) begin
                    for (int i = 0; i < NB; i++) begin
                        if (be[i]) begin
                            mem_d[idx][8*i +: 8] = datoEscritura[8*i +: 8];
                        end
                    end
                end else if (Ren) begin
                    rd_dat_d = mem_q[idx];
                    vld_d    = 1'b1;
                end
            end
            default: begin
                state_d = LIMPIA;
                cnt_d   = '0;
            end
        endcase
    end

    // Array contents are not reset; the clear sequence that follows reset defines them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= LIMPIA;
            cnt_q    <= '0;
            rd_dat_q <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_dat_q <= rd_dat_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            mem_q    <= mem_d;
        end
    end

    assign datoLectura    = rd_dat_q;
    assign lectura_valida = vld_q;
    assign error          = err_q;
    assign ocupado        = (state_q == LIMPIA);

endmodule

// File: tb/tb_mem_out_sync.sv
// Bench for mem_out_sync: a 32x32 instance and a 20x16 instance driven side by side,
// checked every cycle against a word-array reference model through a scoreboard.
module tb_mem_out_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] a0, a1;
    logic        w0, r0, w1, r1;
    logic [3:0]  be0;
    logic [1:0]  be1;
    logic [31:0] d0, q0;
    logic [15:0] d1, q1;
    logic        v0, v1, o0, o1, e0, e1;

    mem_out_sync u0 (
        .clk(clk), .rst_n(rst_n), .direccion(a0), .Wen(w0), .Ren(r0), .be(be0),
        .datoEscritura(d0), .datoLectura(q0), .lectura_valida(v0), .ocupado(o0), .error(e0)
    );

    mem_out_sync #(.ANCHO(16), .PROF(20), .AW(32)) u1 (
        .clk(clk), .rst_n(rst_n), .direccion(a1), .Wen(w1), .Ren(r1), .be(be1),
        .datoEscritura(d1), .datoLectura(q1), .lectura_valida(v1), .ocupado(o1), .error(e1)
    );

    typedef struct packed {
        logic [31:0] dat;
        logic        vld;
        logic        err;
        logic        ocu;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: one word array per instance, clear treated as instantaneous plus a busy count.
    logic [31:0] m_mem [2][32];
    int          m_busy [2];
    logic [31:0] m_dat [2];
    int          prof [2] = '{32, 20};
    int          nbytes [2] = '{4, 2};

    logic        s_rst;
    logic        s_wen [2];
    logic        s_ren [2];
    logic [31:0] s_addr [2];
    logic [31:0] s_dat [2];
    logic [3:0]  s_be [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model(input int k, output exp_t e);
        e.vld = 1'b0;
        e.err = 1'b0;
        if (!s_rst) begin
            for (int j = 0; j < 32; j++) m_mem[k][j] = '0;
            m_busy[k] = prof[k];
            m_dat[k]  = '0;
        end else if (m_busy[k] > 0) begin
            m_busy[k]--;
        end else if (s_wen[k] || s_ren[k]) begin
            if (s_addr[k] >= 32'(prof[k]) || (s_wen[k] && s_ren[k])) begin
                e.err = 1'b1;
            end else if (s_wen[k]) begin
                for (int i = 0; i < nbytes[k]; i++)
                    if (s_be[k][i]) m_mem[k][s_addr[k][4:0]][8*i +: 8] = s_dat[k][8*i +: 8];
            end else begin
                m_dat[k] = m_mem[k][s_addr[k][4:0]];
                e.vld    = 1'b1;
            end
        end
        e.dat = m_dat[k];
        e.ocu = (m_busy[k] > 0);
    endtask

    task automatic idle_stage();
        s_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_wen[k] = 1'b0; s_ren[k] = 1'b0; s_addr[k] = '0; s_dat[k] = '0; s_be[k] = '0;
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = s_rst;
        w0 = s_wen[0]; r0 = s_ren[0]; a0 = s_addr[0]; be0 = s_be[0];      d0 = s_dat[0];
        w1 = s_wen[1]; r1 = s_ren[1]; a1 = s_addr[1]; be1 = s_be[1][1:0]; d1 = s_dat[1][15:0];
        model(0, e); sb0.push_back(e);
        model(1, e); sb1.push_back(e);
        idle_stage();
    endtask

    task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        s_wen[k] = 1'b1; s_ren[k] = 1'b0; s_addr[k] = a; s_be[k] = b;
        s_dat[k] = (k == 1) ? {16'h0, d[15:0]} : d;
    endtask

    task automatic rd(input int k, input logic [31:0] a);
        s_wen[k] = 1'b0; s_ren[k] = 1'b1; s_addr[k] = a;
    endtask

    task automatic rnd(input int k);
        logic [31:0] a;
        int sel;
        sel = $urandom_range(0, 7);
        case ($urandom_range(0, 9))
            0:       a = $urandom;
            1, 2, 3: a = 32'($urandom_range(0, 3));
            default: a = 32'($urandom_range(0, prof[k] + 3));
        endcase
        if (sel <= 2)      wr(k, a, $urandom, 4'($urandom));
        else if (sel <= 5) rd(k, a);
        else if (sel == 6) begin wr(k, a, $urandom, 4'($urandom)); s_ren[k] = 1'b1; end
    endtask

    // Monitor: takes the expectation for the edge just taken, compares once outputs settle.
    initial begin
        exp_t x0, x1;
        forever begin
            @(posedge clk);
            if (sb0.size() > 0 && sb1.size() > 0) begin
                x0 = sb0.pop_front();
                x1 = sb1.pop_front();
                #2;
                chk("u0_dat", q0, x0.dat);
                chk("u0_vld", 32'(v0), 32'(x0.vld));
                chk("u0_err", 32'(e0), 32'(x0.err));
                chk("u0_ocupado", 32'(o0), 32'(x0.ocu));
                chk("u1_dat", {16'h0, q1}, x1.dat);
                chk("u1_vld", 32'(v1), 32'(x1.vld));
                chk("u1_err", 32'(e1), 32'(x1.err));
                chk("u1_ocupado", 32'(o1), 32'(x1.ocu));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        w0 = 1'b0; r0 = 1'b0; a0 = '0; be0 = '0; d0 = '0;
        w1 = 1'b0; r1 = 1'b0; a1 = '0; be1 = '0; d1 = '0;
        idle_stage();

        s_rst = 1'b0; step();
        s_rst = 1'b0; step();
        repeat (32) step();

        rd(0, 0);  rd(1, 0);  step();
        rd(0, 17); rd(1, 19); step();
        rd(0, 31); step();

        wr(0, 5, 32'hDEADBEEF, 4'b1111); step();
        wr(0, 5, 32'h11223344, 4'b0101); step();
        rd(0, 5); step();

        wr(0, 9, 32'hCAFEF00D, 4'b1111); step();
        rd(0, 9); step();
        step();

        rd(0, 32); step();
        step();
        wr(0, 3, 32'h12345678, 4'b1111); step();
        wr(0, 3, 32'hFFFFFFFF, 4'b1111); s_ren[0] = 1'b1; step();
        rd(0, 3); step();
        wr(0, 32'h80000003, 32'h0BADF00D, 4'b1111); step();
        rd(0, 32'h80000003); step();
        rd(0, 3); step();

        wr(0, 7, 32'h55555555, 4'b1111); step();
        wr(0, 7, 32'h00000000, 4'b0000); step();
        rd(0, 7); step();

        wr(1, 25, 32'h1234, 4'b0011); step();
        wr(1, 19, 32'hBEEF, 4'b0011); step();
        rd(1, 19); step();
        rd(1, 20); step();
        rd(1, 31); step();

        wr(0, 2, 32'hAAAAAAAA, 4'b1111); step();
        s_rst = 1'b0; step();
        repeat (32) begin rnd(0); rnd(1); step(); end
        rd(0, 2); step();

        repeat (1500) begin
            rnd(0); rnd(1);
            if ($urandom_range(0, 199) == 0) s_rst = 1'b0;
            step();
        end

        repeat (3) @(posedge clk);
        #3;
        chk("sb_drain", 32'(sb0.size() + sb1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
